control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 167 ++++++++++++++++
 tb/tb_control_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired control sequencer for a single-bus datapath: fetches an
// instruction (T0-T2), decodes the opcode (T3), and drives the ALU
// execute phases (T4-T5) plus a HI write for multiply/divide (T6).
//
// Ports:
//   Clock, Reset     rising-edge clock, asynchronous active-high reset
//   Run              start request, honoured in IDLE and on Done cycles
//   IR               instruction register: opcode[31:27] Ra[26:23] Rb[22:19] Rc[18:15]
//   PCout..HIin      single-bit datapath strobes, decoded from present state
//   Rout, Rin        one-hot register bus select / register load enable
//   operation        ALU operation code (valid in T4)
//   Done, Illegal    instruction-complete / bad-opcode pulses
//   instr_count      completed-instruction counter (wraps)
module control_sequencer #(
   parameter logic [4:0] ALU_LAST = 5'd11,
   parameter logic [4:0] OP_MUL   = 5'd14,
   parameter logic [4:0] OP_DIV   = 5'd15
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Run,
   input  logic [31:0] IR,
   output logic        PCout,
   output logic        MARin,
   output logic        IncPC,
   output logic        Zin,
   output logic        PCin,
   output logic        Read,
   output logic        MDRin,
   output logic        MDRout,
   output logic        IRin,
   output logic        Yin,
   output logic        Zlowout,
   output logic        ZHighout,
   output logic        LOin,
   output logic        HIin,
   output logic [15:0] Rout,
   output logic [15:0] Rin,
   output logic [4:0]  operation,
   output logic        Done,
   output logic        Illegal,
   output logic [15:0] instr_count
);

   localparam int unsigned REG_W = 16;
   localparam int unsigned CNT_W = 16;

   typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, T6} state_t;

   state_t      state;
   state_t      state_nxt;

   logic [4:0]  opcode;
   logic [3:0]  ra;
   logic [3:0]  rb;
   logic [3:0]  rc;
   logic        is_alu;
   logic        is_muldiv;
   logic        unused_ir;

   // Instruction field decode
   assign opcode    = IR[31:27];
   assign ra        = IR[26:23];
   assign rb        = IR[22:19];
   assign rc        = IR[18:15];
   assign is_alu    = (opcode <= ALU_LAST);
   assign is_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);
   assign unused_ir = ^IR[14:0];

   // State register
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Completed-instruction counter
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset)     instr_count <= '0;
      else if (Done) instr_count <= instr_count + CNT_W'(1);
   end

   // Next-state and strobe decode
   always_comb begin
      state_nxt = state;
      PCout     = 1'b0;
      MARin     = 1'b0;
      IncPC     = 1'b0;
      Zin       = 1'b0;
      PCin      = 1'b0;
      Read      = 1'b0;
      MDRin     = 1'b0;
      MDRout    = 1'b0;
      IRin      = 1'b0;
      Yin       = 1'b0;
      Zlowout   = 1'b0;
      ZHighout  = 1'b0;
      LOin      = 1'b0;
      HIin      = 1'b0;
      Rout      = '0;
      Rin       = '0;
      operation = 5'd0;
      Done      = 1'b0;
      Illegal   = 1'b0;

      case (state)
         IDLE: begin
            if (Run) state_nxt = T0;
         end
         T0: begin
            PCout     = 1'b1;
            MARin     = 1'b1;
            IncPC     = 1'b1;
            Zin       = 1'b1;
            state_nxt = T1;
         end
         T1: begin
            Zlowout   = 1'b1;
            PCin      = 1'b1;
            Read      = 1'b1;
            MDRin     = 1'b1;
            state_nxt = T2;
         end
         T2: begin
            MDRout    = 1'b1;
            IRin      = 1'b1;
            state_nxt = T3;
         end
         T3: begin
            if (is_alu || is_muldiv) begin
               Rout      = REG_W'(1) << rb;
               Yin       = 1'b1;
               state_nxt = T4;
            end else begin
               // Unknown opcode: abort without touching registers or the counter
               Illegal   = 1'b1;
               state_nxt = IDLE;
            end
         end
         T4: begin
            Rout      = REG_W'(1) << rc;
            Zin       = 1'b1;
            operation = opcode;
            state_nxt = T5;
         end
         T5: begin
            Zlowout = 1'b1;
            if (is_muldiv) begin
               LOin      = 1'b1;
               state_nxt = T6;
            end else begin
               // Rin stays gated by is_alu in case IR changed after decode
               if (is_alu) Rin = REG_W'(1) << ra;
               Done      = 1'b1;
               state_nxt = Run ? T0 : IDLE;
            end
         end
         T6: begin
            ZHighout  = 1'b1;
            HIin      = 1'b1;
            Done      = 1'b1;
            state_nxt = Run ? T0 : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: table-driven instruction
// vectors expanded into per-cycle expected outputs on a scoreboard queue,
// plus hand-written back-to-back, async-reset and counter-wrap sequences.
module tb_control_sequencer;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        Run;
   logic [31:0] IR;
   logic        PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin;
   logic        Yin, Zlowout, ZHighout, LOin, HIin;
   logic [15:0] Rout, Rin;
   logic [4:0]  operation;
   logic        Done, Illegal;
   logic [15:0] instr_count;

   always #5 Clock = ~Clock;

   control_sequencer dut (
      .Clock(Clock), .Reset(Reset), .Run(Run), .IR(IR),
      .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .PCin(PCin),
      .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
      .Zlowout(Zlowout), .ZHighout(ZHighout), .LOin(LOin), .HIin(HIin),
      .Rout(Rout), .Rin(Rin), .operation(operation), .Done(Done),
      .Illegal(Illegal), .instr_count(instr_count)
   );

   typedef struct packed {
      logic        PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin;
      logic        Yin, Zlowout, ZHighout, LOin, HIin;
      logic [15:0] Rout;
      logic [15:0] Rin;
      logic [4:0]  op;
      logic        Done, Illegal;
   } outs_t;

   localparam int K_ALU = 0;
   localparam int K_MD  = 1;
   localparam int K_ILL = 2;

   typedef struct {
      logic [31:0] ir;
      int          kind;
      logic [15:0] rout3;
      logic [15:0] rout4;
      logic [15:0] rin5;
      logic [4:0]  op;
   } vec_t;

   typedef struct {
      outs_t o;
      int    st;   // -1 = IDLE, 0..6 = T0..T6
   } exp_t;

   exp_t        sb[$];
   int          nchecks = 0;
   int          nfail   = 0;
   logic [15:0] expcnt;
   vec_t        vecs[9];

   // Expected outputs for one state of a given instruction
   function automatic outs_t model(vec_t v, int st);
      outs_t o;
      o = '0;
      case (st)
         0: begin o.PCout = 1'b1; o.MARin = 1'b1; o.IncPC = 1'b1; o.Zin = 1'b1; end
         1: begin o.Zlowout = 1'b1; o.PCin = 1'b1; o.Read = 1'b1; o.MDRin = 1'b1; end
         2: begin o.MDRout = 1'b1; o.IRin = 1'b1; end
         3: begin
            if (v.kind == K_ILL) o.Illegal = 1'b1;
            else begin o.Rout = v.rout3; o.Yin = 1'b1; end
         end
         4: begin o.Rout = v.rout4; o.Zin = 1'b1; o.op = v.op; end
         5: begin
            o.Zlowout = 1'b1;
            if (v.kind == K_MD) o.LOin = 1'b1;
            else begin o.Rin = v.rin5; o.Done = 1'b1; end
         end
         6: begin o.ZHighout = 1'b1; o.HIin = 1'b1; o.Done = 1'b1; end
         default: ;
      endcase
      return o;
   endfunction

   function automatic outs_t sample_outs();
      outs_t o;
      o = {PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin,
           Yin, Zlowout, ZHighout, LOin, HIin, Rout, Rin, operation, Done, Illegal};
      return o;
   endfunction

   task automatic push(vec_t v, int st);
      exp_t e;
      e.o  = model(v, st);
      e.st = st;
      sb.push_back(e);
   endtask

   // Queue the T0.. states of one instruction
   task automatic push_instr(vec_t v);
      int last;
      last = (v.kind == K_ILL) ? 3 : (v.kind == K_MD) ? 6 : 5;
      for (int s = 0; s <= last; s++) push(v, s);
   endtask

   task automatic check_outs(string name, outs_t exp);
      outs_t act;
      act = sample_outs();
      nchecks++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_cnt(string name, logic [15:0] exp);
      nchecks++;
      if (instr_count !== exp) begin
         nfail++;
         $display("FAIL %s: instr_count got %h expected %h", name, instr_count, exp);
      end
   endtask

   // One clock: compare at the falling edge, return 1 time unit after the rising edge
   task automatic step();
      exp_t e;
      @(negedge Clock);
      if (sb.size() == 0) begin
         nchecks++;
         nfail++;
         $display("FAIL scoreboard: empty queue at t=%0t, got %h", $time, sample_outs());
      end else begin
         e = sb.pop_front();
         check_outs($sformatf("state %0d", e.st), e.o);
      end
      @(posedge Clock);
      #1;
   endtask

   // Single instruction from IDLE with a one-cycle Run pulse
   task automatic run_vec(vec_t v, string name);
      IR  = v.ir;
      Run = 1'b1;
      push(v, -1);
      push_instr(v);
      push(v, -1);
      step();
      Run = 1'b0;
      while (sb.size() > 0) step();
      if (v.kind != K_ILL) expcnt = expcnt + 16'd1;
      check_cnt(name, expcnt);
   endtask

   // Rout/Rin must be one-hot or zero on every cycle
   always @(negedge Clock) begin
      if (Reset === 1'b0) begin
         nchecks++;
         if (!$onehot0(Rout)) begin
            nfail++;
            $display("FAIL rout_onehot: got %h required one-hot or zero", Rout);
         end
         nchecks++;
         if (!$onehot0(Rin)) begin
            nfail++;
            $display("FAIL rin_onehot: got %h required one-hot or zero", Rin);
         end
      end
   end

   initial begin
      outs_t zero;
      vec_t  v;
      zero = '0;
      //            ir            kind   rout3     rout4     rin5      op
      vecs[0] = '{32'h521B8000, K_ALU, 16'h0008, 16'h0080, 16'h0010, 5'd10};
      vecs[1] = '{32'h70128000, K_MD,  16'h0004, 16'h0020, 16'h0000, 5'd14};
      vecs[2] = '{32'hF8000000, K_ILL, 16'h0000, 16'h0000, 16'h0000, 5'd0};
      vecs[3] = '{32'h78F80000, K_MD,  16'h8000, 16'h0001, 16'h0000, 5'd15};
      vecs[4] = '{32'h07878000, K_ALU, 16'h0001, 16'h8000, 16'h8000, 5'd0};
      vecs[5] = '{32'h59488000, K_ALU, 16'h0200, 16'h0002, 16'h0004, 5'd11};
      vecs[6] = '{32'h60000000, K_ILL, 16'h0000, 16'h0000, 16'h0000, 5'd0};
      vecs[7] = '{32'h68000000, K_ILL, 16'h0000, 16'h0000, 16'h0000, 5'd0};
      vecs[8] = '{32'h80000000, K_ILL, 16'h0000, 16'h0000, 16'h0000, 5'd0};

      Reset = 1'b0;
      Run   = 1'b0;
      IR    = 32'h0;
      #1 Reset = 1'b1;
      #1;
      check_outs("reset outputs", zero);
      check_cnt("reset count", 16'h0000);
      expcnt = 16'h0000;
      @(posedge Clock);
      @(posedge Clock);
      #1 Reset = 1'b0;

      // Idle without Run stays idle
      push(vecs[0], -1);
      push(vecs[0], -1);
      step();
      step();

      // Table-driven single instructions
      for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d count", i));

      // Back-to-back multiply with Run held: T6 goes straight to T0
      v   = vecs[1];
      IR  = v.ir;
      Run = 1'b1;
      push(v, -1);
      push_instr(v);
      push_instr(v);
      push(v, -1);
      for (int i = 0; i < 9; i++) step();
      Run = 1'b0;
      while (sb.size() > 0) step();
      expcnt = expcnt + 16'd2;
      check_cnt("b2b count", expcnt);

      // Async reset in T4 abandons the instruction and clears the counter
      v   = vecs[0];
      IR  = v.ir;
      Run = 1'b1;
      push(v, -1);
      for (int s = 0; s <= 3; s++) push(v, s);
      step();
      Run = 1'b0;
      while (sb.size() > 0) step();
      check_outs("T4 before reset", model(v, 4));
      #2 Reset = 1'b1;
      #1;
      check_outs("async reset outputs", zero);
      check_cnt("async reset count", 16'h0000);
      expcnt = 16'h0000;
      #1 Reset = 1'b0;
      push(v, -1);
      push(v, -1);
      step();
      step();
      check_cnt("post reset count", expcnt);

      // Counter wrap from FFFF
      force dut.instr_count = 16'hFFFF;
      #1 release dut.instr_count;
      expcnt = 16'hFFFF;
      check_cnt("preset count", expcnt);
      run_vec(vecs[5], "wrap count");
      run_vec(vecs[2], "illegal after wrap count");

      $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
      $finish;
   end

endmodule
